// File: rtl/bus_control_8259_pkg.sv
// Shared types and constants for the 8259-style bus control block:
// the init/command FSM state encoding, data-bit positions and commit-pulse slots.
package bus_control_8259_pkg;

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_e;

    localparam int BIT_D0 = 0;
    localparam int BIT_D1 = 1;
    localparam int BIT_D3 = 3;
    localparam int BIT_D4 = 4;

    localparam int PULSE_W  = 7;
    localparam int P_ICW1   = 0;
    localparam int P_ICW2   = 1;
    localparam int P_ICW3   = 2;
    localparam int P_ICW4   = 3;
    localparam int P_OCW1   = 4;
    localparam int P_OCW2   = 5;
    localparam int P_OCW3   = 6;

endpackage

// File: rtl/bus_control_8259_sync_sync.sv
// Multi-flop synchroniser for one asynchronous bus strobe; resets to the
// strobe's inactive level so no phantom cycle is seen after reset release.
module bus_strobe_synchronizer #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw input through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    end

    // Synchroniser chain flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/bus_control_8259_sync.sv
// CPU bus front end of an 8259-style interrupt controller: synchronises the
// bus strobes, commits writes into ICW/OCW pulses and serves register reads.
module bus_control_8259_sync
    import bus_control_8259_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  chip_select_n,
    input  logic                  read_enable_n,
    input  logic                  write_enable_n,
    input  logic                  address,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    input  logic [DATA_WIDTH-1:0] irr_in,
    input  logic [DATA_WIDTH-1:0] isr_in,
    input  logic [DATA_WIDTH-1:0] imr_in,
    output logic [DATA_WIDTH-1:0] data_bus_out,
    output logic                  data_bus_io_n,
    output logic [DATA_WIDTH-1:0] internal_data_bus,
    output logic                  write_icw1,
    output logic                  write_icw2,
    output logic                  write_icw3,
    output logic                  write_icw4,
    output logic                  write_ocw1,
    output logic                  write_ocw2,
    output logic                  write_ocw3,
    output logic                  init_busy,
    output logic                  single_mode,
    output logic                  icw4_needed,
    output logic                  read_isr_select
);

    logic cs_n_s, rd_n_s, wr_n_s, a0_s;
    logic write_active_s, read_active_s, commit_s;

    logic                  wr_cycle_q, wr_cycle_d;
    logic                  wr_a0_q, wr_a0_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] idb_q, idb_d;
    logic [PULSE_W-1:0]    pulse_q, pulse_d;
    logic                  busy_q, busy_d;
    logic                  single_q, single_d;
    logic                  icw4_q, icw4_d;
    logic                  ris_q, ris_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  io_n_q, io_n_d;

    bus_strobe_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
        .clock(clock), .reset_n(reset_n), .async_in(chip_select_n), .sync_out(cs_n_s));
    bus_strobe_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_rd (
        .clock(clock), .reset_n(reset_n), .async_in(read_enable_n), .sync_out(rd_n_s));
    bus_strobe_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_wr (
        .clock(clock), .reset_n(reset_n), .async_in(write_enable_n), .sync_out(wr_n_s));
    bus_strobe_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_a0 (
        .clock(clock), .reset_n(reset_n), .async_in(address), .sync_out(a0_s));

    // Bus cycle tracking, write commit decode, FSM next state and read mux.
    always_comb begin
        wr_cycle_d = wr_cycle_q;
        wr_a0_d    = wr_a0_q;
        wr_data_d  = wr_data_q;
        state_d    = state_q;
        idb_d      = idb_q;
        pulse_d    = {PULSE_W{1'b0}};
        single_d   = single_q;
        icw4_d     = icw4_q;
        ris_d      = ris_q;
        dout_d     = {DATA_WIDTH{1'b0}};
        io_n_d     = 1'b1;

        write_active_s = !cs_n_s && !wr_n_s;
        read_active_s  = !cs_n_s && !rd_n_s && !write_active_s;
        // A chip-select release while the write strobe is still low clears the
        // cycle without committing, which is how aborted writes vanish.
        commit_s       = wr_cycle_q && wr_n_s;
        wr_cycle_d     = write_active_s;

        if (write_active_s) begin
            wr_a0_d   = a0_s;
            wr_data_d = data_bus_in;
        end else begin
            wr_a0_d   = wr_a0_q;
            wr_data_d = wr_data_q;
        end

        if (commit_s) begin
            idb_d = wr_data_q;
            if (!wr_a0_q && wr_data_q[BIT_D4]) begin
                pulse_d[P_ICW1] = 1'b1;
                single_d        = wr_data_q[BIT_D1];
                icw4_d          = wr_data_q[BIT_D0];
                ris_d           = 1'b0;
                state_d         = WAIT_ICW2;
            end else begin
                case (state_q)
                    WAIT_ICW2: begin
                        if (wr_a0_q) begin
                            pulse_d[P_ICW2] = 1'b1;
                            state_d = !single_q ? WAIT_ICW3 : (icw4_q ? WAIT_ICW4 : READY);
                        end else begin
                            state_d = state_q;
                        end
                    end
                    WAIT_ICW3: begin
                        if (wr_a0_q) begin
                            pulse_d[P_ICW3] = 1'b1;
                            state_d = icw4_q ? WAIT_ICW4 : READY;
                        end else begin
                            state_d = state_q;
                        end
                    end
                    WAIT_ICW4: begin
                        if (wr_a0_q) begin
                            pulse_d[P_ICW4] = 1'b1;
                            state_d = READY;
                        end else begin
                            state_d = state_q;
                        end
                    end
                    READY: begin
                        if (wr_a0_q) begin
                            pulse_d[P_OCW1] = 1'b1;
                        end else if (!wr_data_q[BIT_D3]) begin
                            pulse_d[P_OCW2] = 1'b1;
                        end else begin
                            pulse_d[P_OCW3] = 1'b1;
                            ris_d = wr_data_q[BIT_D1] ? wr_data_q[BIT_D0] : ris_q;
                        end
                    end
                    default: begin
                        state_d = UNINIT;
                    end
                endcase
            end
        end else begin
            idb_d = idb_q;
        end

        busy_d = (state_d == WAIT_ICW2) || (state_d == WAIT_ICW3) || (state_d == WAIT_ICW4);

        if (read_active_s) begin
            io_n_d = 1'b0;
            dout_d = a0_s ? imr_in : (ris_q ? isr_in : irr_in);
        end else begin
            io_n_d = 1'b1;
            dout_d = {DATA_WIDTH{1'b0}};
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_cycle_q <= 1'b0;
            wr_a0_q    <= 1'b0;
            wr_data_q  <= {DATA_WIDTH{1'b0}};
            state_q    <= UNINIT;
            idb_q      <= {DATA_WIDTH{1'b0}};
            pulse_q    <= {PULSE_W{1'b0}};
            busy_q     <= 1'b0;
            single_q   <= 1'b0;
            icw4_q     <= 1'b0;
            ris_q      <= 1'b0;
            dout_q     <= {DATA_WIDTH{1'b0}};
            io_n_q     <= 1'b1;
        end else begin
            wr_cycle_q <= wr_cycle_d;
            wr_a0_q    <= wr_a0_d;
            wr_data_q  <= wr_data_d;
            state_q    <= state_d;
            idb_q      <= idb_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            single_q   <= single_d;
            icw4_q     <= icw4_d;
            ris_q      <= ris_d;
            dout_q     <= dout_d;
            io_n_q     <= io_n_d;
        end
    end

    assign data_bus_out      = dout_q;
    assign data_bus_io_n     = io_n_q;
    assign internal_data_bus = idb_q;
    assign write_icw1        = pulse_q[P_ICW1];
    assign write_icw2        = pulse_q[P_ICW2];
    assign write_icw3        = pulse_q[P_ICW3];
    assign write_icw4        = pulse_q[P_ICW4];
    assign write_ocw1        = pulse_q[P_OCW1];
    assign write_ocw2        = pulse_q[P_OCW2];
    assign write_ocw3        = pulse_q[P_OCW3];
    assign init_busy         = busy_q;
    assign single_mode       = single_q;
    assign icw4_needed       = icw4_q;
    assign read_isr_select   = ris_q;

endmodule

// File: tb/tb_bus_control_8259_sync.sv
// Randomised bench for bus_control_8259_sync against a transaction-level
// model of the ICW/OCW command protocol and register readback.
module tb_bus_control_8259_sync;

    localparam int SYNC = 2;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       chip_select_n, read_enable_n, write_enable_n, address;
    logic [7:0] data_bus_in, irr_in, isr_in, imr_in;
    logic [7:0] data_bus_out, internal_data_bus;
    logic       data_bus_io_n;
    logic       write_icw1, write_icw2, write_icw3, write_icw4;
    logic       write_ocw1, write_ocw2, write_ocw3;
    logic       init_busy, single_mode, icw4_needed, read_isr_select;

    bus_control_8259_sync #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC)) dut (
        .clock(clock), .reset_n(reset_n),
        .chip_select_n(chip_select_n), .read_enable_n(read_enable_n),
        .write_enable_n(write_enable_n), .address(address),
        .data_bus_in(data_bus_in), .irr_in(irr_in), .isr_in(isr_in), .imr_in(imr_in),
        .data_bus_out(data_bus_out), .data_bus_io_n(data_bus_io_n),
        .internal_data_bus(internal_data_bus),
        .write_icw1(write_icw1), .write_icw2(write_icw2), .write_icw3(write_icw3),
        .write_icw4(write_icw4), .write_ocw1(write_ocw1), .write_ocw2(write_ocw2),
        .write_ocw3(write_ocw3), .init_busy(init_busy), .single_mode(single_mode),
        .icw4_needed(icw4_needed), .read_isr_select(read_isr_select)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Every high cycle of any commit pulse is logged; bit 0 = icw1 ... bit 6 = ocw3.
    logic [6:0] pulse_log[$];
    always @(negedge clock) begin
        if ({write_ocw3, write_ocw2, write_ocw1, write_icw4, write_icw3, write_icw2, write_icw1} != 7'd0)
            pulse_log.push_back({write_ocw3, write_ocw2, write_ocw1, write_icw4,
                                 write_icw3, write_icw2, write_icw1});
    end

    // Reference model: 0 uninitialised, 1..3 awaiting ICW2..ICW4, 4 operational.
    int         m_phase;
    logic       m_single, m_icw4, m_ris;
    logic [7:0] m_idb;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic void model_reset();
        m_phase = 0; m_single = 1'b0; m_icw4 = 1'b0; m_ris = 1'b0; m_idb = 8'h00;
    endfunction

    // Returns which command the byte is (0..6 as in pulse_log) or -1 if ignored.
    function automatic int model_write(input logic a0, input logic [7:0] d);
        int p;
        p = -1;
        m_idb = d;
        if (!a0 && d[4]) begin
            p = 0; m_single = d[1]; m_icw4 = d[0]; m_ris = 1'b0; m_phase = 1;
        end else if (a0 && m_phase == 1) begin
            p = 1;
            if (!m_single) m_phase = 2;
            else           m_phase = m_icw4 ? 3 : 4;
        end else if (a0 && m_phase == 2) begin
            p = 2; m_phase = m_icw4 ? 3 : 4;
        end else if (a0 && m_phase == 3) begin
            p = 3; m_phase = 4;
        end else if (m_phase == 4) begin
            if (a0)        p = 4;
            else if (!d[3]) p = 5;
            else begin
                p = 6;
                if (d[1]) m_ris = d[0];
            end
        end
        return p;
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, ".idb"},    internal_data_bus, m_idb);
        check_eq({tag, ".busy"},   init_busy, (m_phase >= 1 && m_phase <= 3) ? 1 : 0);
        check_eq({tag, ".single"}, single_mode, m_single);
        check_eq({tag, ".icw4"},   icw4_needed, m_icw4);
        check_eq({tag, ".ris"},    read_isr_select, m_ris);
    endtask

    task automatic bus_write(input logic a0, input logic [7:0] d, input bit abort);
        int         exp_p;
        logic [6:0] got;
        pulse_log.delete();
        @(posedge clock); #1;
        address = a0; data_bus_in = d; chip_select_n = 1'b0; write_enable_n = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        if (abort) chip_select_n = 1'b1;
        else       write_enable_n = 1'b1;
        repeat (2) @(posedge clock);
        #1; chip_select_n = 1'b1; write_enable_n = 1'b1;
        repeat (SYNC + 4) @(posedge clock);
        #1;
        exp_p = abort ? -1 : model_write(a0, d);
        check_eq(abort ? "abort.npulse" : "wr.npulse", pulse_log.size(), (exp_p >= 0) ? 1 : 0);
        got = (pulse_log.size() > 0) ? pulse_log[0] : 7'd0;
        check_eq(abort ? "abort.pulse" : "wr.pulse", got, (exp_p >= 0) ? (32'd1 << exp_p) : 32'd0);
        check_state(abort ? "abort" : "wr");
    endtask

    task automatic bus_read(input logic a0);
        logic [7:0] exp;
        @(posedge clock); #1;
        address = a0; chip_select_n = 1'b0; read_enable_n = 1'b0;
        repeat (SYNC + 3) @(posedge clock);
        #1;
        exp = a0 ? imr_in : (m_ris ? isr_in : irr_in);
        check_eq("rd.data", data_bus_out, exp);
        check_eq("rd.io_n", data_bus_io_n, 1'b0);
        chip_select_n = 1'b1; read_enable_n = 1'b1;
        repeat (SYNC + 3) @(posedge clock);
        #1;
        check_eq("idle.data", data_bus_out, 8'h00);
        check_eq("idle.io_n", data_bus_io_n, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".data"},  data_bus_out, 8'h00);
        check_eq({tag, ".io_n"},  data_bus_io_n, 1'b1);
        check_eq({tag, ".pulse"}, {write_ocw3, write_ocw2, write_ocw1, write_icw4,
                                   write_icw3, write_icw2, write_icw1}, 7'd0);
        check_state(tag);
    endtask

    initial begin
        reset_n = 1'b0; chip_select_n = 1'b1; read_enable_n = 1'b1; write_enable_n = 1'b1;
        address = 1'b0; data_bus_in = 8'h00;
        irr_in = 8'h00; isr_in = 8'h00; imr_in = 8'h00;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        // Uninitialised: only ICW1 is honoured.
        bus_write(1'b1, 8'hFF, 1'b0);
        // Single mode, ICW4 needed: icw1, icw2, icw4.
        bus_write(1'b0, 8'h13, 1'b0);
        bus_write(1'b1, 8'h20, 1'b0);
        bus_write(1'b1, 8'h01, 1'b0);
        // Cascade: icw1..icw4 with busy held until icw4.
        bus_write(1'b0, 8'h11, 1'b0);
        bus_write(1'b0, 8'h05, 1'b0);
        bus_write(1'b1, 8'h08, 1'b0);
        bus_write(1'b1, 8'h04, 1'b0);
        bus_write(1'b1, 8'h01, 1'b0);
        // OCW3 selects ISR for readback.
        bus_write(1'b0, 8'h0B, 1'b0);
        isr_in = 8'h5A; irr_in = 8'hA5; imr_in = 8'h3C;
        bus_read(1'b0);
        bus_read(1'b1);
        bus_write(1'b0, 8'h20, 1'b0);
        bus_write(1'b1, 8'hFE, 1'b0);
        bus_write(1'b1, 8'h77, 1'b1);

        // Reset while awaiting ICW3.
        bus_write(1'b0, 8'h11, 1'b0);
        bus_write(1'b1, 8'h08, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("rst_icw3");
        reset_n = 1'b1;
        bus_write(1'b1, 8'h04, 1'b0);

        // Reset in the middle of a write strobe discards it.
        bus_write(1'b0, 8'h13, 1'b0);
        pulse_log.delete();
        @(posedge clock); #1;
        address = 1'b1; data_bus_in = 8'h20; chip_select_n = 1'b0; write_enable_n = 1'b0;
        repeat (4) @(posedge clock);
        #1; reset_n = 1'b0; chip_select_n = 1'b1; write_enable_n = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1; reset_n = 1'b1;
        repeat (SYNC + 4) @(posedge clock);
        #1;
        check_eq("rst_wr.npulse", pulse_log.size(), 0);
        check_state("rst_wr");

        // Random transactions against the model.
        for (int i = 0; i < 80; i++) begin
            int         kind;
            logic [7:0] d;
            logic       a0;
            kind = $urandom_range(0, 9);
            d    = 8'($urandom);
            a0   = 1'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                a0 = 1'b0;
                d  = d | 8'h10;
            end else if (!a0 && $urandom_range(0, 1) == 0) begin
                d = d & 8'hEF;
            end
            irr_in = 8'($urandom); isr_in = 8'($urandom); imr_in = 8'($urandom);
            if (kind < 2)       bus_read(a0);
            else if (kind == 2) bus_write(a0, d, 1'b1);
            else                bus_write(a0, d, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
